// File: rtl/project_pwm_peripheral_pkg.sv
// Shared constants for the PWM peripheral: counting modes and direction states.
package project_pwm_peripheral_pkg;
  localparam logic MODE_UP     = 1'b0;
  localparam logic MODE_UPDOWN = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;
endpackage

// File: rtl/project_pwm_peripheral_prescaler.sv
// Clock divider: one-clock o_tick every i_prescale+1 enabled clocks; held at 0 while disabled.
module project_pwm_peripheral_prescaler
  import project_pwm_peripheral_pkg::*;
#(
  parameter int PRESC_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_enable,
  input  logic [PRESC_WIDTH-1:0] i_prescale,
  output logic                   o_tick
);
  localparam logic [PRESC_WIDTH-1:0] ONE = PRESC_WIDTH'(1);

  logic [PRESC_WIDTH-1:0] presc_q, presc_d;

  assign o_tick = i_enable && (presc_q == i_prescale);

  always_comb begin
    presc_d = presc_q + ONE;
    if (!i_enable || o_tick) presc_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) presc_q <= '0;
    else            presc_q <= presc_d;
  end
endmodule

// File: rtl/project_pwm_peripheral_counter.sv
// Period timebase, direction FSM, shadowed period/duty and duty comparator producing raw PWM.
module project_pwm_peripheral_counter
  import project_pwm_peripheral_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PRESC_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_enable,
  input  logic                   i_mode,
  input  logic [PRESC_WIDTH-1:0] i_prescale,
  input  logic [WIDTH-1:0]       i_period,
  input  logic [WIDTH-1:0]       i_duty,
  input  logic                   i_load,
  output logic                   o_pwm,
  output logic [WIDTH-1:0]       o_count,
  output logic                   o_period_end,
  output logic                   o_load_pending
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             tick;
  logic             boundary;
  logic [WIDTH-1:0] count_q, count_d;
  dir_e             dir_q, dir_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] per_act_q, per_act_d, duty_act_q, duty_act_d;
  logic [WIDTH-1:0] per_pend_q, per_pend_d, duty_pend_q, duty_pend_d;
  logic             pend_flag_q, pend_flag_d;
  logic             pe_q, pe_d;
  logic             pwm_q, pwm_d;

  project_pwm_peripheral_prescaler #(.PRESC_WIDTH(PRESC_WIDTH)) u_presc (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_enable   (i_enable),
    .i_prescale (i_prescale),
    .o_tick     (tick)
  );

  always_comb begin
    count_d     = count_q;
    dir_d       = dir_q;
    mode_d      = mode_q;
    per_act_d   = per_act_q;
    duty_act_d  = duty_act_q;
    per_pend_d  = per_pend_q;
    duty_pend_d = duty_pend_q;
    pend_flag_d = pend_flag_q;
    boundary    = 1'b0;

    if (!i_enable) begin
      count_d = '0;
      dir_d   = DIR_UP;
      mode_d  = i_mode;
      if (i_load) begin
        per_pend_d  = i_period;
        duty_pend_d = i_duty;
        per_act_d   = i_period;
        duty_act_d  = i_duty;
        pend_flag_d = 1'b0;
      end
    end else begin
      if (tick) begin
        if (mode_q == MODE_UP || per_act_q == '0) begin
          if (count_q == per_act_q) begin
            count_d  = '0;
            boundary = 1'b1;
          end else begin
            count_d = count_q + ONE;
          end
        end else if (dir_q == DIR_UP) begin
          count_d = count_q + ONE;
          if (count_q == per_act_q - ONE) dir_d = DIR_DOWN;
        end else begin
          count_d = count_q - ONE;
          if (count_q == ONE) begin
            dir_d    = DIR_UP;
            boundary = 1'b1;
          end
        end
      end
      // Boundary copies the old pending set; a coincident load then refills pending.
      if (boundary) begin
        per_act_d   = per_pend_q;
        duty_act_d  = duty_pend_q;
        mode_d      = i_mode;
        pend_flag_d = 1'b0;
      end
      if (i_load) begin
        per_pend_d  = i_period;
        duty_pend_d = i_duty;
        pend_flag_d = 1'b1;
      end
    end

    pe_d  = boundary;
    pwm_d = i_enable && (count_d < duty_act_d);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q     <= '0;
      dir_q       <= DIR_UP;
      mode_q      <= MODE_UP;
      per_act_q   <= '0;
      duty_act_q  <= '0;
      per_pend_q  <= '0;
      duty_pend_q <= '0;
      pend_flag_q <= 1'b0;
      pe_q        <= 1'b0;
      pwm_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      dir_q       <= dir_d;
      mode_q      <= mode_d;
      per_act_q   <= per_act_d;
      duty_act_q  <= duty_act_d;
      per_pend_q  <= per_pend_d;
      duty_pend_q <= duty_pend_d;
      pend_flag_q <= pend_flag_d;
      pe_q        <= pe_d;
      pwm_q       <= pwm_d;
    end
  end

  assign o_pwm          = pwm_q;
  assign o_count        = count_q;
  assign o_period_end   = pe_q;
  assign o_load_pending = pend_flag_q;
endmodule

// File: tb/tb_project_pwm_peripheral_counter.sv
// Bench for the PWM timebase: phase-based reference model plus directed waveform checks.
module tb_project_pwm_peripheral_counter;
  localparam int W  = 8;
  localparam int PW = 4;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_enable = 1'b0;
  logic          i_mode = 1'b0;
  logic          i_load = 1'b0;
  logic [PW-1:0] i_prescale = '0;
  logic [W-1:0]  i_period = '0;
  logic [W-1:0]  i_duty = '0;
  logic          o_pwm, o_period_end, o_load_pending;
  logic [W-1:0]  o_count;

  int compared = 0;
  int mismatched = 0;

  // Model state: position within the period rather than count/direction.
  int m_phase, m_presc, m_pend_p, m_pend_d, m_act_p, m_act_d, m_count;
  bit m_flag, m_mode, m_pe, m_pwm;

  project_pwm_peripheral_counter #(.WIDTH(W), .PRESC_WIDTH(PW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_mode(i_mode),
    .i_prescale(i_prescale), .i_period(i_period), .i_duty(i_duty), .i_load(i_load),
    .o_pwm(o_pwm), .o_count(o_count), .o_period_end(o_period_end),
    .o_load_pending(o_load_pending)
  );

  always #5 i_clk = ~i_clk;

  function automatic void model_reset();
    m_phase = 0; m_presc = 0; m_pend_p = 0; m_pend_d = 0; m_act_p = 0; m_act_d = 0;
    m_count = 0; m_flag = 0; m_mode = 0; m_pe = 0; m_pwm = 0;
  endfunction

  function automatic void model_step();
    bit tick, bnd;
    int len;
    bnd = 0;
    if (!i_enable) begin
      m_phase = 0; m_presc = 0; m_mode = i_mode;
      if (i_load) begin
        m_pend_p = int'(i_period); m_pend_d = int'(i_duty);
        m_act_p = m_pend_p; m_act_d = m_pend_d; m_flag = 0;
      end
    end else begin
      tick = (m_presc == int'(i_prescale));
      m_presc = tick ? 0 : m_presc + 1;
      if (tick) begin
        len = (m_act_p == 0) ? 1 : (m_mode ? 2 * m_act_p : m_act_p + 1);
        m_phase++;
        if (m_phase >= len) begin m_phase = 0; bnd = 1; end
      end
      if (bnd) begin m_act_p = m_pend_p; m_act_d = m_pend_d; m_mode = i_mode; m_flag = 0; end
      if (i_load) begin m_pend_p = int'(i_period); m_pend_d = int'(i_duty); m_flag = 1; end
    end
    m_pe = bnd;
    m_count = (m_mode && m_phase > m_act_p) ? 2 * m_act_p - m_phase : m_phase;
    m_pwm = i_enable && (m_count < m_act_d);
  endfunction

  function automatic logic [W+2:0] exp_vec();
    return {m_pwm, m_pe, m_flag, W'(m_count)};
  endfunction

  function automatic logic [W+2:0] obs_vec();
    return {o_pwm, o_period_end, o_load_pending, o_count};
  endfunction

  task automatic step();
    model_step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load_disabled(input int p, input int d, input bit mode, input int presc);
    i_enable = 0; step();
    i_mode = mode; i_prescale = PW'(presc); i_period = W'(p); i_duty = W'(d); i_load = 1;
    step();
    i_load = 0;
  endtask

  task automatic test_reset();
    model_reset();
    i_reset_n = 0;
    #2;
    if (obs_vec() !== '0) begin
      mismatched++; $display("FAIL reset: got %h want 0", obs_vec());
    end
    compared++;
    @(posedge i_clk); #1;
    i_reset_n = 1;
    step();
    if (obs_vec() !== exp_vec()) begin
      mismatched++; $display("FAIL reset_idle: got %h want %h", obs_vec(), exp_vec());
    end
    compared++;
  endtask

  task automatic test_up_basic();
    int highs, ends;
    load_disabled(9, 3, 0, 0);
    if (o_load_pending !== 1'b0) begin
      mismatched++; $display("FAIL up_load_flag: got %b want 0", o_load_pending);
    end
    compared++;
    i_enable = 1;
    highs = 0; ends = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (obs_vec() !== exp_vec()) begin
        mismatched++; $display("FAIL up_basic c%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      compared++;
      if (i >= 20 && i < 30) highs += int'(o_pwm);
      ends += int'(o_period_end);
    end
    if (highs != 3 || ends != 4) begin
      mismatched++; $display("FAIL up_shape: highs %0d ends %0d want 3 and 4", highs, ends);
    end
    compared++;
  endtask

  task automatic test_prescaler();
    int highs, changes;
    logic [W-1:0] prev;
    load_disabled(4, 2, 0, 3);
    i_enable = 1;
    highs = 0; changes = 0; prev = o_count;
    for (int i = 0; i < 80; i++) begin
      step();
      if (obs_vec() !== exp_vec()) begin
        mismatched++; $display("FAIL presc c%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      compared++;
      if (i >= 40 && i < 60) begin
        highs += int'(o_pwm);
        changes += int'(o_count != prev);
      end
      prev = o_count;
    end
    if (highs != 8 || changes != 5) begin
      mismatched++; $display("FAIL presc_shape: highs %0d changes %0d want 8 and 5", highs, changes);
    end
    compared++;
  endtask

  task automatic test_center();
    int highs, ends;
    int seq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};
    load_disabled(4, 2, 1, 0);
    i_enable = 1;
    highs = 0; ends = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (obs_vec() !== exp_vec() || o_count !== W'(seq[(i + 1) % 8])) begin
        mismatched++; $display("FAIL center c%0d: got %h want %h seq %0d", i, obs_vec(), exp_vec(), seq[(i + 1) % 8]);
      end
      compared++;
      if (i >= 16 && i < 24) highs += int'(o_pwm);
      ends += int'(o_period_end);
    end
    if (highs != 3 || ends != 5) begin
      mismatched++; $display("FAIL center_shape: highs %0d ends %0d want 3 and 5", highs, ends);
    end
    compared++;
  endtask

  task automatic test_shadow();
    int highs, n;
    load_disabled(9, 3, 0, 0);
    i_enable = 1;
    n = 0;
    while (o_count !== W'(4) && n < 30) begin step(); n++; end
    i_period = 9; i_duty = 6; i_load = 1;
    step();
    i_load = 0;
    if (o_load_pending !== 1'b1 || n >= 30) begin
      mismatched++; $display("FAIL shadow_flag: got %b want 1 (wait %0d)", o_load_pending, n);
    end
    compared++;
    n = 0;
    while (o_period_end !== 1'b1 && n < 20) begin
      step(); n++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++; $display("FAIL shadow_old c%0d: got %h want %h", n, obs_vec(), exp_vec());
      end
      compared++;
    end
    highs = int'(o_pwm);
    if (o_load_pending !== 1'b0 || n >= 20) begin
      mismatched++; $display("FAIL shadow_clear: got %b want 0 (wait %0d)", o_load_pending, n);
    end
    compared++;
    for (int i = 0; i < 9; i++) begin step(); highs += int'(o_pwm); end
    if (highs != 6) begin
      mismatched++; $display("FAIL shadow_new: highs %0d want 6", highs);
    end
    compared++;
  endtask

  task automatic test_load_boundary();
    int highs, n;
    n = 0;
    while (o_count !== W'(9) && n < 30) begin step(); n++; end
    i_period = 9; i_duty = 2; i_load = 1;
    step();
    i_load = 0;
    if (o_period_end !== 1'b1 || o_load_pending !== 1'b1 || n >= 30) begin
      mismatched++; $display("FAIL lb_coincide: got pe %b lp %b want 1 1", o_period_end, o_load_pending);
    end
    compared++;
    highs = int'(o_pwm);
    for (int i = 0; i < 9; i++) begin
      step(); highs += int'(o_pwm);
      if (o_load_pending !== 1'b1 || obs_vec() !== exp_vec()) begin
        mismatched++; $display("FAIL lb_hold c%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      compared++;
    end
    step();
    if (highs != 6 || o_period_end !== 1'b1 || o_load_pending !== 1'b0) begin
      mismatched++; $display("FAIL lb_apply: highs %0d pe %b lp %b want 6 1 0", highs, o_period_end, o_load_pending);
    end
    compared++;
    highs = int'(o_pwm);
    for (int i = 0; i < 9; i++) begin step(); highs += int'(o_pwm); end
    if (highs != 2) begin
      mismatched++; $display("FAIL lb_new: highs %0d want 2", highs);
    end
    compared++;
  endtask

  task automatic test_edges();
    int p [3] = '{9, 9, 0};
    int d [3] = '{0, 10, 0};
    for (int k = 0; k < 3; k++) begin
      load_disabled(p[k], d[k], 0, 0);
      i_enable = 1;
      for (int i = 0; i < 20; i++) begin
        step();
        if (obs_vec() !== exp_vec() || (k == 0 && o_pwm !== 1'b0) ||
            (k == 1 && o_pwm !== 1'b1) || (k == 2 && o_period_end !== 1'b1)) begin
          mismatched++; $display("FAIL edge%0d c%0d: got %h want %h", k, i, obs_vec(), exp_vec());
        end
        compared++;
      end
    end
    load_disabled(9, 5, 0, 0);
    i_enable = 1;
    for (int i = 0; i < 4; i++) step();
    i_reset_n = 0;
    #1;
    if (obs_vec() !== '0) begin
      mismatched++; $display("FAIL mid_reset: got %h want 0", obs_vec());
    end
    compared++;
    model_reset();
    i_enable = 0;
    @(posedge i_clk); #1;
    i_reset_n = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        i_enable = ~i_enable;
        if (!i_enable) i_prescale = PW'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 9) == 0) i_mode = ~i_mode;
      i_load = ($urandom_range(0, 7) == 0);
      i_period = W'($urandom_range(0, 12));
      i_duty = W'($urandom_range(0, 14));
      step();
      if (obs_vec() !== exp_vec()) begin
        mismatched++; $display("FAIL random c%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      compared++;
    end
    i_load = 0;
  endtask

  initial begin
    test_reset();
    test_up_basic();
    test_prescaler();
    test_center();
    test_shadow();
    test_load_boundary();
    test_edges();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
